// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter; slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [3:0]        p0_sign_mask;
   logic              p0_gnt;
   logic              p0_done;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_err;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic [3:0]        p1_sign_mask;
   logic              p1_gnt;
   logic              p1_done;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_memread;
   logic              mem_memwrite;
   logic [3:0]        mem_sign_mask;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_clk_stall;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_sign_mask,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask,
      input  mem_read_data, mem_clk_stall,
      output p0_gnt, p0_done, p0_rdata, p0_err,
      output p1_gnt, p1_done, p1_rdata, p1_err,
      output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_sign_mask,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask,
      output mem_read_data, mem_clk_stall,
      input  p0_gnt, p0_done, p0_rdata, p0_err,
      input  p1_gnt, p1_done, p1_rdata, p1_err,
      input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin share of one data-memory port: gnt+strobe 1 cycle after req, done 3 cycles after gnt; losers hold req.
// Optional bounded WAIT (done with err on stall timeout) enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic           clk,
   input logic           rst_n,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   // The first WAIT cycle never completes, so a shorter bound could not be honoured.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t            r_state;
   logic              r_last;
   logic              r_win;
   logic              r_we;
   logic              r_first;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [3:0]        r_mem_mask;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic              r_p0_gnt, r_p1_gnt;
   logic              r_p0_done, r_p1_done;
   logic              r_p0_err, r_p1_err;
   logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

   logic w_any, w_pick1, w_we_sel, w_timeout, w_err, w_finish;

   assign w_any    = bus.p0_req | bus.p1_req;
   assign w_pick1  = bus.p1_req & (~bus.p0_req | ~r_last);
   assign w_we_sel = w_pick1 ? bus.p1_we : bus.p0_we;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_wait_cnt <= '0;
      else if (r_state == S_ISSUE) r_wait_cnt <= '0;
      else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + CNT_W'(1);
   end

   assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign w_err    = w_timeout & bus.mem_clk_stall;
   assign w_finish = (~r_first & ~bus.mem_clk_stall) | w_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_win       <= 1'b0;
         r_we        <= 1'b0;
         r_first     <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_mask  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_p0_gnt    <= 1'b0;
         r_p1_gnt    <= 1'b0;
         r_p0_done   <= 1'b0;
         r_p1_done   <= 1'b0;
         r_p0_err    <= 1'b0;
         r_p1_err    <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
      end else begin
         r_mem_rd   <= 1'b0;
         r_mem_wr   <= 1'b0;
         r_p0_gnt   <= 1'b0;
         r_p1_gnt   <= 1'b0;
         r_p0_done  <= 1'b0;
         r_p1_done  <= 1'b0;
         r_p0_err   <= 1'b0;
         r_p1_err   <= 1'b0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_win       <= w_pick1;
                  r_last      <= w_pick1;
                  r_we        <= w_we_sel;
                  r_mem_addr  <= w_pick1 ? bus.p1_addr      : bus.p0_addr;
                  r_mem_wdata <= w_pick1 ? bus.p1_wdata     : bus.p0_wdata;
                  r_mem_mask  <= w_pick1 ? bus.p1_sign_mask : bus.p0_sign_mask;
                  r_p0_gnt    <= ~w_pick1;
                  r_p1_gnt    <= w_pick1;
                  r_mem_rd    <= ~w_we_sel;
                  r_mem_wr    <= w_we_sel;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_first <= 1'b1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_first <= 1'b0;
               if (w_finish) begin
                  r_p0_done <= ~r_win;
                  r_p1_done <= r_win;
                  r_p0_err  <= ~r_win & w_err;
                  r_p1_err  <= r_win & w_err;
                  if (!r_win) r_p0_rdata <= (r_we | w_err) ? '0 : bus.mem_read_data;
                  else        r_p1_rdata <= (r_we | w_err) ? '0 : bus.mem_read_data;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.p0_gnt         = r_p0_gnt;
   assign bus.p1_gnt         = r_p1_gnt;
   assign bus.p0_done        = r_p0_done;
   assign bus.p1_done        = r_p1_done;
   assign bus.p0_err         = r_p0_err;
   assign bus.p1_err         = r_p1_err;
   assign bus.p0_rdata       = r_p0_rdata;
   assign bus.p1_rdata       = r_p1_rdata;
   assign bus.mem_addr       = r_mem_addr;
   assign bus.mem_write_data = r_mem_wdata;
   assign bus.mem_sign_mask  = r_mem_mask;
   assign bus.mem_memread    = r_mem_rd;
   assign bus.mem_memwrite   = r_mem_wr;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected strobes/dones; a negedge monitor pops and compares.
module tb_dmem_arbiter;
   typedef struct packed {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } cmd_t;

   typedef struct packed {
      bit          port;
      logic [31:0] rdata;
      bit          err;
      int          lat;
   } done_t;

   logic        clk;
   logic        rst_n;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          gnt_cyc [2];
   cmd_t        exp_cmd [$];
   done_t       exp_done [$];
   cmd_t        mon_c;
   done_t       mon_d;
   bit          got_port;
   logic [31:0] got_rdata;
   bit          got_err;
   int          stall_len = 1;
   int          stall_cnt = 0;
   logic [31:0] rd_reg = '0;

   dmem_arbiter_if bus ();

   dmem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_lookup(input logic [31:0] a);
      case (a)
         32'h0000_1004: return 32'hDEAD_BEEF;
         32'h0000_2000: return 32'h1111_2222;
         32'h0000_3000: return 32'h3333_4444;
         default:       return 32'h0;
      endcase
   endfunction

   // Memory model: stall for stall_len cycles after each strobe, read data held from the strobe edge.
   always @(posedge clk) begin
      if (bus.mem_memread || bus.mem_memwrite) begin
         stall_cnt <= stall_len;
         if (bus.mem_memread) rd_reg <= mem_lookup(bus.mem_addr);
      end else if (stall_cnt > 0) begin
         stall_cnt <= stall_cnt - 1;
      end
   end

   assign bus.mem_clk_stall = (stall_cnt != 0);
   assign bus.mem_read_data = rd_reg;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.p0_gnt) gnt_cyc[0] = cyc;
         if (bus.p1_gnt) gnt_cyc[1] = cyc;
         if (bus.mem_memread || bus.mem_memwrite || bus.p0_gnt || bus.p1_gnt) begin
            checks++;
            if (exp_cmd.size() == 0) begin
               failures++;
               $display("FAIL strobe_unexpected rd=%0b wr=%0b gnt0=%0b gnt1=%0b required no activity",
                        bus.mem_memread, bus.mem_memwrite, bus.p0_gnt, bus.p1_gnt);
            end else begin
               mon_c = exp_cmd.pop_front();
               if (!((bus.mem_memread != bus.mem_memwrite) && (bus.p0_gnt != bus.p1_gnt) &&
                     (bus.p1_gnt == mon_c.port) && (bus.mem_memwrite == mon_c.we) &&
                     (bus.mem_addr == mon_c.addr) && (bus.mem_sign_mask == mon_c.mask) &&
                     (!mon_c.we || bus.mem_write_data == mon_c.wdata))) begin
                  failures++;
                  $display("FAIL cmd_check got rd=%0b wr=%0b gnt0=%0b gnt1=%0b addr=%h wdata=%h mask=%b required port=%0d we=%0b addr=%h wdata=%h mask=%b",
                           bus.mem_memread, bus.mem_memwrite, bus.p0_gnt, bus.p1_gnt, bus.mem_addr,
                           bus.mem_write_data, bus.mem_sign_mask, mon_c.port, mon_c.we, mon_c.addr,
                           mon_c.wdata, mon_c.mask);
               end
            end
         end
         if (bus.p0_done || bus.p1_done) begin
            checks++;
            got_port  = bus.p1_done;
            got_rdata = got_port ? bus.p1_rdata : bus.p0_rdata;
            got_err   = got_port ? bus.p1_err : bus.p0_err;
            if (exp_done.size() == 0) begin
               failures++;
               $display("FAIL done_unexpected done0=%0b done1=%0b required none", bus.p0_done, bus.p1_done);
            end else begin
               mon_d = exp_done.pop_front();
               if (!((bus.p0_done != bus.p1_done) && (got_port == mon_d.port) &&
                     (got_rdata == mon_d.rdata) && (got_err == mon_d.err) &&
                     (mon_d.lat == 0 || (cyc - gnt_cyc[got_port]) == mon_d.lat))) begin
                  failures++;
                  $display("FAIL done_check got port=%0d rdata=%h err=%0b lat=%0d required port=%0d rdata=%h err=%0b lat=%0d",
                           got_port, got_rdata, got_err, cyc - gnt_cyc[got_port],
                           mon_d.port, mon_d.rdata, mon_d.err, mon_d.lat);
               end
            end
         end
      end
   end

   task automatic push_cmd(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
      cmd_t c;
      c.port = port; c.we = we; c.addr = addr; c.wdata = wdata; c.mask = mask;
      exp_cmd.push_back(c);
   endtask

   task automatic push_done(input bit port, input logic [31:0] rdata, input bit err, input int lat);
      done_t d;
      d.port = port; d.rdata = rdata; d.err = err; d.lat = lat;
      exp_done.push_back(d);
   endtask

   // Raise req, wait (bounded) for gnt, drop req; waited = cycles from raise to gnt.
   task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, output int waited);
      bit seen = 1'b0;
      if (port) begin
         bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata; bus.p1_sign_mask = mask; bus.p1_req = 1'b1;
      end else begin
         bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata; bus.p0_sign_mask = mask; bus.p0_req = 1'b1;
      end
      waited = 0;
      while (!seen && waited < 40) begin
         @(negedge clk);
         waited++;
         seen = port ? bus.p1_gnt : bus.p0_gnt;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL gnt_timeout port=%0d waited=%0d required gnt within 40", port, waited);
      end
      if (port) bus.p1_req = 1'b0;
      else      bus.p0_req = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((exp_cmd.size() != 0 || exp_done.size() != 0) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (exp_cmd.size() != 0 || exp_done.size() != 0) begin
         failures++;
         $display("FAIL %s pending cmd=%0d done=%0d required 0 0", name, exp_cmd.size(), exp_done.size());
      end
   endtask

   task automatic check_zero(input string name);
      logic [139:0] v;
      v = {bus.p0_gnt, bus.p1_gnt, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err,
           bus.p0_rdata, bus.p1_rdata, bus.mem_addr, bus.mem_write_data,
           bus.mem_memread, bus.mem_memwrite, bus.mem_sign_mask};
      checks++;
      if (v != '0) begin
         failures++;
         $display("FAIL %s outputs=%h required 0", name, v);
      end
   endtask

   task automatic quiet(input string name, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge clk);
         #1;
         if (bus.mem_memread || bus.mem_memwrite || bus.p0_done || bus.p1_done) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL %s activity_cycles=%0d required 0", name, seen);
      end
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_sign_mask = '0;
      bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_sign_mask = '0;
      repeat (2) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while the grant/strobe cycle is showing.
      push_cmd(0, 0, 32'h1004, 32'h0, 4'b0111);
      issue(0, 0, 32'h1004, 32'h0, 4'b0111, w);
      #2 rst_n = 1'b0;
      #1 check_zero("reset_in_issue");
      exp_cmd.delete();
      exp_done.delete();
      @(negedge clk);
      rst_n = 1'b1;
      quiet("idle_after_reset", 4);

      // Single p0 read, nominal one-cycle stall.
      stall_len = 1;
      push_cmd(0, 0, 32'h1004, 32'h0, 4'b0111);
      push_done(0, 32'hDEAD_BEEF, 0, 3);
      issue(0, 0, 32'h1004, 32'h0, 4'b0111, w);
      checks++;
      if (w != 1) begin
         failures++;
         $display("FAIL p0_gnt_latency waited=%0d required 1", w);
      end
      drain("p0_read_drain", 20);

      // p1 byte write: rdata returned as 0.
      push_cmd(1, 1, 32'h1001, 32'h0000_00AB, 4'b0001);
      push_done(1, 32'h0, 0, 3);
      issue(1, 1, 32'h1001, 32'h0000_00AB, 4'b0001, w);
      drain("p1_write_drain", 20);

      // Both ports contend for four accesses: strict alternation starting with p0.
      push_cmd(0, 0, 32'h2000, 32'h0, 4'b0111);
      push_cmd(1, 1, 32'h2100, 32'h5566_7788, 4'b0111);
      push_cmd(0, 0, 32'h3000, 32'h0, 4'b0111);
      push_cmd(1, 0, 32'h1004, 32'h0, 4'b0111);
      push_done(0, 32'h1111_2222, 0, 3);
      push_done(1, 32'h0, 0, 3);
      push_done(0, 32'h3333_4444, 0, 3);
      push_done(1, 32'hDEAD_BEEF, 0, 3);
      fork
         begin
            int w0;
            issue(0, 0, 32'h2000, 32'h0, 4'b0111, w0);
            issue(0, 0, 32'h3000, 32'h0, 4'b0111, w0);
         end
         begin
            int w1;
            issue(1, 1, 32'h2100, 32'h5566_7788, 4'b0111, w1);
            issue(1, 0, 32'h1004, 32'h0, 4'b0111, w1);
         end
      join
      drain("contend_drain", 40);

      // Reset during WAIT: outputs clear at once and the aborted access never completes.
      push_cmd(0, 0, 32'h2000, 32'h0, 4'b0111);
      issue(0, 0, 32'h2000, 32'h0, 4'b0111, w);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("reset_in_wait");
      exp_cmd.delete();
      exp_done.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      quiet("no_done_after_abort", 6);
      push_cmd(0, 0, 32'h1004, 32'h0, 4'b0111);
      push_done(0, 32'hDEAD_BEEF, 0, 3);
      issue(0, 0, 32'h1004, 32'h0, 4'b0111, w);
      drain("read_after_abort_drain", 20);

      // Long stall: bounded by the timeout when enabled, otherwise waits for the memory.
      stall_len = 20;
      push_cmd(0, 0, 32'h1004, 32'h0, 4'b0111);
`ifdef DMEM_ARB_TIMEOUT_EN
      push_done(0, 32'h0, 1, 17);
`else
      push_done(0, 32'hDEAD_BEEF, 0, 22);
`endif
      issue(0, 0, 32'h1004, 32'h0, 4'b0111, w);
      drain("long_stall_drain", 60);
      stall_len = 1;
      quiet("idle_at_end", 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog time=%0t required completion", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
